des_key_sched: RTL and testbench
================================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have start, input, 1, request a 16-subkey run; accepted only when ready=1.
REQ-004 SHALL have key, input, 64, DES key, bit 63 = FIPS bit 1; sampled on accepted start.
REQ-005 SHALL have decrypt, input, 1, 0 = emit K1..K16, 1 = emit K16..K1; sampled on accepted start.
REQ-006 SHALL have ready, output, 1, high in IDLE only.
REQ-007 SHALL have sk_valid, output, 1, subkey/round_idx valid.
REQ-008 SHALL have sk_ready, input, 1, consumer accepts subkey when sk_valid & sk_ready.
REQ-009 SHALL have subkey, output, 48, PC-2 output, bit 47 = FIPS bit 1.
REQ-010 SHALL have round_idx, output, 4, DES round number minus 1 of current subkey.
REQ-011 SHALL have last, output, 1, high with sk_valid on the 16th subkey.
REQ-012 SHALL have parity_err, output, 1, one-cycle pulse on rejected key.

Function
REQ-013 SHALL implement states IDLE and RUN; IDLE->RUN on start&ready; RUN->IDLE on handshake of the last subkey.
REQ-014 SHALL on accepted start load 56-bit C/D register with PC-1(key) and clear 4-bit step counter.
REQ-015 SHALL in RUN, when !sk_valid or sk_ready, rotate C and D independently, load rotated value into C/D, register PC-2(rotated) into subkey, set sk_valid, increment step.
REQ-016 SHALL use encrypt rotates left, per step 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 SHALL use decrypt rotates right, per step 0..15: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-018 SHALL drive round_idx = step (encrypt) or 15-step (decrypt).
REQ-019 SHALL hold subkey, round_idx, last, sk_valid stable while sk_valid & !sk_ready.
REQ-020 SHALL, with sk_ready held high, give sk_valid on 16 consecutive cycles, first at second rising edge after start edge.
REQ-021 SHALL clear sk_valid on the handshake of the last subkey; ready rises the same edge.
REQ-022 SHALL ignore start while in RUN; key/decrypt changes during RUN have no effect.
REQ-023 SHALL accept start on the cycle ready is high even if sk_ready low.

Reset
REQ-024 SHALL on rst force IDLE, ready=1, sk_valid=0, last=0, parity_err=0, subkey=0, round_idx=0, C/D=0, step=0, immediately and independent of clk.
REQ-025 SHALL on rst mid-run abandon the run; no further subkeys emitted until a new start.

Configuration
REQ-026 SHALL, with DES_KEY_PARITY_CHK_EN defined, check odd parity of each key byte on start; any even byte: stay IDLE, pulse parity_err one cycle, emit no subkeys.
REQ-027 SHALL, without DES_KEY_PARITY_CHK_EN, tie parity_err to 0 and ignore key parity bits.

Verification
REQ-028 SHALL test key 133457799BBCDFF1, decrypt=0, sk_ready=1 -> round_idx 0 subkey 1B02EFFC7072, round_idx 15 subkey CB3D8B0E17F5, last with round_idx 15, 16 valids.
REQ-029 SHALL test same key, decrypt=1 -> first subkey CB3D8B0E17F5 round_idx 15, last subkey 1B02EFFC7072 round_idx 0.
REQ-030 SHALL test sk_ready toggled randomly -> identical subkey sequence as REQ-028, outputs stable during stalls.
REQ-031 SHALL test start pulsed during RUN with other key -> ignored, sequence unchanged.
REQ-032 SHALL test rst asserted after 5th subkey -> sk_valid=0, ready=1 asynchronously; new start restarts at round_idx 0.
REQ-033 SHALL test key 133457799BBCDFF0 with DES_KEY_PARITY_CHK_EN -> parity_err pulse, no sk_valid; without macro -> normal 16 subkeys.

Source files
------------

// File: rtl/des_key_sched.sv
// DES key schedule: emits the 16 round subkeys (forward or reverse order) over a valid/ready stream.
// Optional key-byte odd-parity check is compiled in with DES_KEY_PARITY_CHK_EN.
module des_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        ready,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        last,
  output logic        parity_err,
  output logic        dbg_state
);

  // Stream handshake: subkey/round_idx/last are meaningful while sk_valid=1 and are
  // held unchanged until the cycle where sk_valid & sk_ready transfers them.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Table entries use FIPS numbering where bit 1 is the MSB.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [63:0] t;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      t = k >> (64 - PC1[i]);
      r = {r[54:0], t[0]};
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [55:0] t;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      t = cd >> (56 - PC2[i]);
      r = {r[46:0], t[0]};
    end
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                        input logic right);
    logic [27:0] r;
    case (n)
      2'd1:    r = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2'd2:    r = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  step_q, step_d;
  logic        dec_q, dec_d;
  logic        valid_q, valid_d;
  logic [47:0] subkey_q, subkey_d;
  logic [3:0]  ridx_q, ridx_d;
  logic        last_q, last_d;
  logic [1:0]  shamt;
  logic [55:0] cd_rot;
  logic        key_bad;

  // Decrypt walks the encrypt schedule backwards: step 0 reuses PC-1 as-is (net rotation 28).
  always_comb begin
    shamt = 2'd2;
    if (step_q == 4'd0)
      shamt = dec_q ? 2'd0 : 2'd1;
    else if (step_q == 4'd1 || step_q == 4'd8 || step_q == 4'd15)
      shamt = 2'd1;
  end

  assign cd_rot = {rot28(cd_q[55:28], shamt, dec_q), rot28(cd_q[27:0], shamt, dec_q)};

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    step_d   = step_q;
    dec_d    = dec_q;
    valid_d  = valid_q;
    subkey_d = subkey_q;
    ridx_d   = ridx_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (start && !key_bad) begin
          state_d = RUN;
          cd_d    = pc1(key);
          step_d  = 4'd0;
          dec_d   = decrypt;
        end
      end
      RUN: begin
        if (valid_q && sk_ready && last_q) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (!valid_q || sk_ready) begin
          cd_d     = cd_rot;
          subkey_d = pc2(cd_rot);
          valid_d  = 1'b1;
          ridx_d   = dec_q ? (4'd15 - step_q) : step_q;
          last_d   = (step_q == 4'd15);
          step_d   = step_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cd_q     <= '0;
      step_q   <= '0;
      dec_q    <= 1'b0;
      valid_q  <= 1'b0;
      subkey_q <= '0;
      ridx_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      step_q   <= step_d;
      dec_q    <= dec_d;
      valid_q  <= valid_d;
      subkey_q <= subkey_d;
      ridx_q   <= ridx_d;
      last_q   <= last_d;
    end
  end

`ifdef DES_KEY_PARITY_CHK_EN
  logic [7:0] byte_odd;
  logic       perr_q;

  for (genvar b = 0; b < 8; b++) begin : g_par
    assign byte_odd[b] = ^key[8*b +: 8];
  end

  assign key_bad = ~&byte_odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= (state_q == IDLE) && start && key_bad;
  end

  assign parity_err = perr_q;
`else
  assign key_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign ready     = (state_q == IDLE);
  assign sk_valid  = valid_q;
  assign subkey    = subkey_q;
  assign round_idx = ridx_q;
  assign last      = last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Bench for des_key_sched: textbook DES key-schedule model feeding an expected queue,
// compared on every falling clock edge against the subkey stream.
module tb_des_key_sched;

  localparam logic [63:0] LIT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] BAD_KEY = 64'h133457799BBCDFF0;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] key;
  logic        decrypt;
  logic        ready;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        last;
  logic        parity_err;
  logic        dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [52:0] exp_q[$];
  logic [52:0] obs_q[$];
  logic [47:0] m_ks [16];

  des_key_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .decrypt    (decrypt),
    .ready      (ready),
    .sk_valid   (sk_valid),
    .sk_ready   (sk_ready),
    .subkey     (subkey),
    .round_idx  (round_idx),
    .last       (last),
    .parity_err (parity_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: act=%h req=%h", nm, act, req);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [27:0] rotl_by(input logic [27:0] x, input int s);
    logic [55:0] t;
    t = {x, x} << s;
    return t[55:28];
  endfunction

  task automatic model_keys(input logic [63:0] k);
    logic [55:0] cd0, cd;
    logic [63:0] t;
    logic [47:0] ks;
    int tot;
    cd0 = '0;
    for (int i = 0; i < 56; i++) begin
      t = k >> (64 - PC1[i]);
      cd0 = {cd0[54:0], t[0]};
    end
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += SHIFTS[r];
      cd = {rotl_by(cd0[55:28], tot % 28), rotl_by(cd0[27:0], tot % 28)};
      ks = '0;
      for (int j = 0; j < 48; j++) begin
        ks = {ks[46:0], cd[56 - PC2[j]]};
      end
      m_ks[r] = ks;
    end
  endtask

  task automatic push_expected(input logic [63:0] k, input logic dec);
    int r;
    logic [3:0] r4;
    model_keys(k);
    for (int i = 0; i < 16; i++) begin
      r  = dec ? 15 - i : i;
      r4 = r[3:0];
      exp_q.push_back({(i == 15), r4, m_ks[r]});
    end
  endtask

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] r, t;
    logic [7:0]  by;
    r = '0;
    for (int b = 7; b >= 0; b--) begin
      t  = k >> (8 * b);
      by = t[7:0];
      by[0] = ~^by[7:1];
      r = {r[55:0], by};
    end
    return r;
  endfunction

  // ---------------- compare process (scoreboard) ----------------
  always @(negedge clk) begin
    logic [52:0] e;
    if (exp_q.size() != 0) begin
      if (sk_valid === 1'b1) begin
        e = exp_q[0];
        chk("subkey", {16'h0, subkey}, {16'h0, e[47:0]});
        chk("round_idx", {60'h0, round_idx}, {60'h0, e[51:48]});
        chk("last", {63'h0, last}, {63'h0, e[52]});
        if (sk_ready) begin
          void'(exp_q.pop_front());
          obs_q.push_back({last, round_idx, subkey});
        end
      end
    end else begin
      chk("idle_no_valid", {63'h0, sk_valid}, 64'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_key(input logic [63:0] k, input logic dec, input bit rnd_ready,
                         input bit inject);
    int cyc;
    chk("ready_before_start", {63'h0, ready}, 64'h1);
    obs_q.delete();
    push_expected(k, dec);
    sk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    key      = k;
    decrypt  = dec;
    start    = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    key     = {$urandom, $urandom};
    decrypt = ~dec;
    chk("ready_low_in_run", {63'h0, ready}, 64'h0);
    chk("state_run", {63'h0, dbg_state}, 64'h1);
    chk("no_valid_at_load", {63'h0, sk_valid}, 64'h0);
    chk("parity_quiet", {63'h0, parity_err}, 64'h0);
    @(posedge clk); #1;
    chk("first_valid", {63'h0, sk_valid}, 64'h1);
    cyc = 0;
    while ((exp_q.size() != 0 || !ready) && cyc < 400) begin
      if (rnd_ready) sk_ready = 1'($urandom_range(0, 1));
      if (!rnd_ready)
        chk("valid_streaming", {63'h0, sk_valid}, {63'h0, (exp_q.size() != 0)});
      if (inject && cyc == 4) begin
        start   = 1'b1;
        key     = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    sk_ready = 1'b1;
    chk("run_finished", {63'h0, (cyc < 400)}, 64'h1);
    if (!rnd_ready) chk("stream_cycles", cyc, 16);
    chk("ready_after_run", {63'h0, ready}, 64'h1);
    chk("valid_after_run", {63'h0, sk_valid}, 64'h0);
    chk("subkey_count", obs_q.size(), 16);
  endtask

  task automatic check_literal_ends(input logic dec);
    logic [52:0] f, l;
    if (obs_q.size() != 16) begin
      chk("lit_obs_size", obs_q.size(), 16);
    end else begin
      f = obs_q[0];
      l = obs_q[15];
      chk("lit_first_subkey", {16'h0, f[47:0]}, dec ? 64'hCB3D8B0E17F5 : 64'h1B02EFFC7072);
      chk("lit_first_ridx", {60'h0, f[51:48]}, dec ? 64'd15 : 64'd0);
      chk("lit_last_subkey", {16'h0, l[47:0]}, dec ? 64'h1B02EFFC7072 : 64'hCB3D8B0E17F5);
      chk("lit_last_ridx", {60'h0, l[51:48]}, dec ? 64'd0 : 64'd15);
      chk("lit_last_flag", {63'h0, l[52]}, 64'h1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [63:0] rk;
    rst      = 1'b1;
    start    = 1'b0;
    key      = '0;
    decrypt  = 1'b0;
    sk_ready = 1'b0;
    #1;
    chk("rst_ready", {63'h0, ready}, 64'h1);
    chk("rst_valid", {63'h0, sk_valid}, 64'h0);
    chk("rst_subkey", {16'h0, subkey}, 64'h0);
    chk("rst_ridx", {60'h0, round_idx}, 64'h0);
    chk("rst_last", {63'h0, last}, 64'h0);
    chk("rst_parity", {63'h0, parity_err}, 64'h0);
    chk("rst_state", {63'h0, dbg_state}, 64'h0);

    // Pin the model against published values for the textbook key.
    model_keys(LIT_KEY);
    chk("model_k1", {16'h0, m_ks[0]}, 64'h1B02EFFC7072);
    chk("model_k2", {16'h0, m_ks[1]}, 64'h79AED9DBC9E5);
    chk("model_k16", {16'h0, m_ks[15]}, 64'hCB3D8B0E17F5);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_key(LIT_KEY, 1'b0, 1'b0, 1'b0);
    check_literal_ends(1'b0);
    run_key(LIT_KEY, 1'b1, 1'b0, 1'b0);
    check_literal_ends(1'b1);
    run_key(LIT_KEY, 1'b0, 1'b1, 1'b0);
    check_literal_ends(1'b0);
    run_key(LIT_KEY, 1'b0, 1'b1, 1'b1);
    check_literal_ends(1'b0);
    run_key(LIT_KEY, 1'b1, 1'b0, 1'b1);
    check_literal_ends(1'b1);

    // Asynchronous reset after the fifth subkey has been taken.
    obs_q.delete();
    push_expected(LIT_KEY, 1'b0);
    sk_ready = 1'b1;
    key      = LIT_KEY;
    decrypt  = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (obs_q.size() < 5 && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("reached_5th", obs_q.size(), 5);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_valid", {63'h0, sk_valid}, 64'h0);
    chk("midrst_ready", {63'h0, ready}, 64'h1);
    chk("midrst_ridx", {60'h0, round_idx}, 64'h0);
    chk("midrst_last", {63'h0, last}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", {63'h0, sk_valid}, 64'h0);
    run_key(LIT_KEY, 1'b0, 1'b0, 1'b0);
    check_literal_ends(1'b0);

    // Key with one even-parity byte.
`ifdef DES_KEY_PARITY_CHK_EN
    key   = BAD_KEY;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("perr_pulse", {63'h0, parity_err}, 64'h1);
    chk("perr_ready", {63'h0, ready}, 64'h1);
    chk("perr_state", {63'h0, dbg_state}, 64'h0);
    chk("perr_no_valid", {63'h0, sk_valid}, 64'h0);
    @(posedge clk); #1;
    chk("perr_one_cycle", {63'h0, parity_err}, 64'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("perr_still_idle", {63'h0, ready}, 64'h1);
`else
    run_key(BAD_KEY, 1'b0, 1'b0, 1'b0);
`endif

    // Random keys, directions, consumer back-pressure and mid-run start pulses.
    repeat (8) begin
      rk = {$urandom, $urandom};
`ifdef DES_KEY_PARITY_CHK_EN
      rk = fix_parity(rk);
`endif
      run_key(rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
